// File: rtl/regfile_scanner_if.sv
// Word stream from the register-file scanner to a trace sink.
// A word moves on a rising clk when OutValid && OutReady. While OutValid is high and OutReady is low, OutData and OutRegNum hold steady.
interface regfile_scanner_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic [ADDR_W-1:0] OutRegNum;

    modport master (output OutValid, output OutData, output OutRegNum, input OutReady);
    modport slave  (input OutValid, input OutData, input OutRegNum, output OutReady);
endinterface

// File: rtl/regfile_scanner.sv
// Walks a register-file read port over FirstReg..LastReg and streams each word.
// Each word carries its register number. The module keeps a mod-2^32 checksum of the accepted words.
module regfile_scanner #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] RegNum,
    input  logic [DATA_W-1:0] RegData,
    regfile_scanner_if.master stream,
    output logic              Busy,
    output logic              Done,
    output logic              RangeErr,
    output logic [DATA_W-1:0] Checksum,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] last_reg;
    logic              start_ok, range_bad, capture, accept, abort_scan, at_last;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_ok) state_next = S_READ;
            S_READ: state_next = Abort ? S_IDLE : S_SEND;
            S_SEND: begin
                if (Abort)       state_next = S_IDLE;
                else if (accept) state_next = at_last ? S_DONE : S_READ;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // RegNum doubles as the scan pointer; it only advances when the last register has not been reached, so it never wraps.
    always_comb begin
        start_ok   = (state == S_IDLE) && Start && (FirstReg <= LastReg);
        range_bad  = (state == S_IDLE) && Start && (FirstReg > LastReg);
        capture    = (state == S_READ) && !Abort;
        abort_scan = ((state == S_READ) || (state == S_SEND)) && Abort;
        accept     = (state == S_SEND) && stream.OutValid && stream.OutReady && !Abort;
        at_last    = (RegNum == last_reg);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            RegNum           <= '0;
            last_reg         <= '0;
            stream.OutValid  <= 1'b0;
            stream.OutData   <= '0;
            stream.OutRegNum <= '0;
            Checksum         <= '0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            RangeErr         <= 1'b0;
        end else begin
            RangeErr <= range_bad;
            Done     <= (state_next == S_DONE);
            Busy     <= (state_next == S_READ) || (state_next == S_SEND);
            if (start_ok) begin
                RegNum   <= FirstReg;
                last_reg <= LastReg;
                Checksum <= '0;
            end
            if (capture) begin
                stream.OutData   <= RegData;
                stream.OutRegNum <= RegNum;
                stream.OutValid  <= 1'b1;
            end else if (accept || abort_scan) begin
                stream.OutValid <= 1'b0;
            end
            if (accept) begin
                Checksum <= Checksum + stream.OutData;
                if (!at_last) RegNum <= RegNum + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_scanner.sv
// Bench for regfile_scanner: a register-file array model, a scan driver and per-feature test tasks.
// Expected words and checksums come from the register contents and the requested range.
module tb_regfile_scanner;
    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [4:0]  first_reg, last_reg, reg_num;
    logic [31:0] reg_data, checksum;
    logic        busy, done, range_err;
    logic [1:0]  dbg_state;
    logic [31:0] rf [32];

    localparam logic [1:0] IDLE_ST = 2'd0;

    logic [36:0] exp_q [$];
    logic [36:0] got_q [$];
    int pass_cnt = 0, total_cnt = 0;
    int done_cnt, lat, stable_err, busy_err, rerr_cnt, stall_seen, timed_out, accepted;

    regfile_scanner_if bus ();

    regfile_scanner dut (
        .clk(clk), .Reset(reset), .Start(start), .Abort(abort),
        .FirstReg(first_reg), .LastReg(last_reg), .RegNum(reg_num), .RegData(reg_data),
        .stream(bus), .Busy(busy), .Done(done), .RangeErr(range_err),
        .Checksum(checksum), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    assign reg_data = rf[reg_num];

    function automatic void build_exp(input int f, input int l);
        exp_q.delete();
        for (int r = f; r <= l; r++) exp_q.push_back({5'(r), rf[r]});
    endfunction

    function automatic logic [31:0] exp_sum(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = s + exp_q[i][31:0];
        return s;
    endfunction

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Drives one scan starting at a negedge with the DUT idle.
    // Records the accepted words in got_q and ends one cycle after Done or after an abort.
    task automatic run_scan(input int f, input int l, input int stall_pct, input int stall_reg,
                            input int stall_len, input int abort_word, input bit start_busy,
                            input int mutate_reg);
        logic [31:0] hold_data = '0;
        logic [4:0]  hold_reg = '0;
        bit hold_valid = 0, finished = 0, aborted = 0, mutated = 0, ready, ab;
        int left = stall_len;
        got_q.delete();
        done_cnt = 0; lat = -1; stable_err = 0; busy_err = 0; rerr_cnt = 0;
        stall_seen = 0; timed_out = 0; accepted = 0;
        start = 1; first_reg = 5'(f); last_reg = 5'(l);
        @(negedge clk);
        start = 0;
        for (int c = 1; c < 600 && !finished; c++) begin
            if (bus.OutValid && lat < 0) lat = c;
            if (done) done_cnt++;
            if (range_err) rerr_cnt++;
            if (bus.OutValid && !busy) busy_err++;
            if (hold_valid && (!bus.OutValid || bus.OutData !== hold_data || bus.OutRegNum !== hold_reg))
                stable_err++;
            if (done || (aborted && !busy)) begin
                finished = 1;
            end else begin
                ready = ($urandom_range(99, 0) >= stall_pct);
                if (bus.OutValid && int'(bus.OutRegNum) == stall_reg && left > 0) begin
                    ready = 0; left--; stall_seen++;
                end
                ab = bus.OutValid && ready && (accepted == abort_word);
                if (bus.OutValid && int'(bus.OutRegNum) == mutate_reg && !mutated) begin
                    rf[mutate_reg] = ~rf[mutate_reg];
                    mutated = 1;
                end
                if (bus.OutValid && ready) begin
                    if (!ab) got_q.push_back({bus.OutRegNum, bus.OutData});
                    accepted++;
                end
                hold_valid = bus.OutValid && !ready;
                hold_data = bus.OutData;
                hold_reg = bus.OutRegNum;
                if (ab) aborted = 1;
                bus.OutReady = ready;
                abort = ab;
                start = start_busy && busy;
                if (start) begin
                    first_reg = 5'($urandom);
                    last_reg = 5'($urandom);
                end
                @(negedge clk);
                abort = 0;
            end
        end
        if (!finished) timed_out = 1;
        start = 0; abort = 0; bus.OutReady = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; start = 0; abort = 0; first_reg = '0; last_reg = '0; bus.OutReady = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({reg_num, bus.OutData, bus.OutRegNum, checksum} !== '0) $display("FAIL reset_data got=%h want=0", {reg_num, bus.OutData, bus.OutRegNum, checksum});
        else pass_cnt++;
        total_cnt++;
        if ({bus.OutValid, busy, done, range_err} !== 4'b0) $display("FAIL reset_flags got=%b want=0000", {bus.OutValid, busy, done, range_err});
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE_ST) $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE_ST);
        else pass_cnt++;
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 32; i++) rf[i] = 32'($urandom);
        rf[1] = 20; rf[2] = 40; rf[3] = 10;
        build_exp(1, 3);
        run_scan(1, 3, 0, -1, 0, -1, 0, -1);
        total_cnt++;
        if (timed_out != 0) $display("FAIL basic_timeout got=%0d want=0", timed_out); else pass_cnt++;
        total_cnt++;
        if (lat != 2) $display("FAIL basic_latency got=%0d want=2", lat); else pass_cnt++;
        total_cnt++;
        if (first_diff() != -1) $display("FAIL basic_words got=%0d words want=%0d (diff at %0d)", got_q.size(), exp_q.size(), first_diff());
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL basic_done got=%0d want=1", done_cnt); else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'd70) $display("FAIL basic_checksum got=%0d want=70", checksum); else pass_cnt++;
        total_cnt++;
        if ({done, busy, dbg_state} !== {1'b0, 1'b0, IDLE_ST}) $display("FAIL basic_after got=%b want=00%b", {done, busy, dbg_state}, IDLE_ST);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        rf[1] = 20; rf[2] = 40; rf[3] = 10;
        build_exp(1, 3);
        run_scan(1, 3, 0, 2, 5, -1, 0, -1);
        total_cnt++;
        if (stall_seen != 5 || stable_err != 0) $display("FAIL bp_stable got stall=%0d unstable=%0d want stall=5 unstable=0", stall_seen, stable_err);
        else pass_cnt++;
        total_cnt++;
        if (first_diff() != -1) $display("FAIL bp_words got=%0d want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'd70) $display("FAIL bp_checksum got=%0d want=70", checksum); else pass_cnt++;
    endtask

    task automatic test_full_range();
        for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
        build_exp(0, 31);
        run_scan(0, 31, 0, -1, 0, -1, 0, -1);
        total_cnt++;
        if (first_diff() != -1 || got_q.size() != 32 || got_q[31][36:32] !== 5'd31)
            $display("FAIL full_words got=%0d words want=32 ending at r31", got_q.size());
        else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'hFFFF_FFE0) $display("FAIL full_checksum got=%h want=ffffffe0", checksum); else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || busy_err != 0 || timed_out != 0) $display("FAIL full_ctrl got done=%0d busyerr=%0d to=%0d want 1/0/0", done_cnt, busy_err, timed_out);
        else pass_cnt++;
    endtask

    task automatic test_range_err();
        start = 1; first_reg = 5'd5; last_reg = 5'd2;
        @(negedge clk);
        start = 0;
        total_cnt++;
        if ({range_err, busy, bus.OutValid} !== 3'b100) $display("FAIL rangeerr_pulse got=%b want=100", {range_err, busy, bus.OutValid});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({range_err, busy, bus.OutValid} !== 3'b000) $display("FAIL rangeerr_once got=%b want=000", {range_err, busy, bus.OutValid});
        else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'hFFFF_FFE0) $display("FAIL rangeerr_checksum got=%h want=ffffffe0", checksum); else pass_cnt++;
    endtask

    task automatic test_abort();
        int late_done = 0, late_busy = 0;
        rf[1] = 20; rf[2] = 40; rf[3] = 10;
        build_exp(1, 3);
        run_scan(1, 3, 0, -1, 0, 1, 1, -1);
        repeat (3) begin
            if (done) late_done++;
            if (busy || bus.OutValid) late_busy++;
            @(negedge clk);
        end
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL abort_words got=%0d want=1", got_q.size()); else pass_cnt++;
        total_cnt++;
        if (checksum !== exp_sum(1)) $display("FAIL abort_checksum got=%0d want=%0d", checksum, exp_sum(1)); else pass_cnt++;
        total_cnt++;
        if (done_cnt + late_done != 0) $display("FAIL abort_done got=%0d want=0", done_cnt + late_done); else pass_cnt++;
        total_cnt++;
        if (late_busy != 0 || rerr_cnt != 0 || timed_out != 0) $display("FAIL abort_idle got busy=%0d rerr=%0d to=%0d want 0/0/0", late_busy, rerr_cnt, timed_out);
        else pass_cnt++;
    endtask

    task automatic test_write_during_scan();
        for (int i = 0; i < 32; i++) rf[i] = 32'($urandom);
        build_exp(4, 6);
        run_scan(4, 6, 0, 5, 3, -1, 0, 5);
        total_cnt++;
        if (first_diff() != -1 || stable_err != 0) $display("FAIL wr_words got diff=%0d unstable=%0d want -1/0", first_diff(), stable_err);
        else pass_cnt++;
        total_cnt++;
        if (checksum !== exp_sum(3)) $display("FAIL wr_checksum got=%h want=%h", checksum, exp_sum(3)); else pass_cnt++;
    endtask

    task automatic test_random();
        int f, l;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'($urandom);
            f = $urandom_range(31, 0);
            l = $urandom_range(31, f);
            build_exp(f, l);
            run_scan(f, l, 30, -1, 0, -1, bit'($urandom_range(1, 0)), -1);
            total_cnt++;
            if (first_diff() != -1) $display("FAIL rand_words it=%0d range=%0d..%0d got=%0d want=%0d", it, f, l, got_q.size(), exp_q.size());
            else pass_cnt++;
            total_cnt++;
            if (checksum !== exp_sum(exp_q.size())) $display("FAIL rand_checksum it=%0d got=%h want=%h", it, checksum, exp_sum(exp_q.size()));
            else pass_cnt++;
            total_cnt++;
            if (done_cnt != 1 || stable_err != 0 || busy_err != 0 || rerr_cnt != 0 || timed_out != 0)
                $display("FAIL rand_ctrl it=%0d got done=%0d unstable=%0d busyerr=%0d rerr=%0d to=%0d want 1/0/0/0/0", it, done_cnt, stable_err, busy_err, rerr_cnt, timed_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_send();
        rf[1] = 20; rf[2] = 40; rf[3] = 10;
        bus.OutReady = 0;
        start = 1; first_reg = 5'd1; last_reg = 5'd3;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 10 && !bus.OutValid; i++) @(negedge clk);
        total_cnt++;
        if (bus.OutValid !== 1'b1) $display("FAIL rst_send_reach got=%b want=1", bus.OutValid); else pass_cnt++;
        reset = 1;
        @(negedge clk);
        total_cnt++;
        if ({reg_num, bus.OutData, bus.OutRegNum, checksum, bus.OutValid, busy, done, range_err} !== '0)
            $display("FAIL rst_send_outputs got=%h want=0", {reg_num, bus.OutData, bus.OutRegNum, checksum, bus.OutValid, busy, done, range_err});
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE_ST) $display("FAIL rst_send_state got=%0d want=%0d", dbg_state, IDLE_ST); else pass_cnt++;
        reset = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_range();
        test_range_err();
        test_abort();
        test_write_during_scan();
        test_random();
        test_reset_in_send();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
